// File: rtl/synth_pkg.sv
// Shared synth definitions: envelope state encoding and full-scale level,
// used by the ADSR envelope and the planned multi-voice mixer.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int unsigned LEVEL_W_DEFAULT = 16;
    localparam logic [LEVEL_W_DEFAULT-1:0] LEVEL_MAX = '1;

endpackage

// File: rtl/env_vca.sv
// Two-stage VCA: signed sample times unsigned Q0.LEVEL_W level, arithmetic
// shift back to sample width; one result per clock, two clocks of latency.
module env_vca #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned LEVEL_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_in_valid,
    input  logic        [LEVEL_W-1:0]  level,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid
);

    localparam int unsigned PW = SAMPLE_W + LEVEL_W + 1;

    logic                       s1_valid;
    logic signed [SAMPLE_W-1:0] s1_sample;
    logic        [LEVEL_W-1:0]  s1_level;
    logic signed [PW-1:0]       a_ext;
    logic signed [PW-1:0]       b_ext;
    logic signed [PW-1:0]       prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_level  <= '0;
        end else begin
            s1_valid <= sample_in_valid;
            if (sample_in_valid) begin
                s1_sample <= sample_in;
                s1_level  <= level;
            end
        end
    end

    // Level is zero-extended so the multiply stays signed without flipping its sign.
    assign a_ext = {{(LEVEL_W+1){s1_sample[SAMPLE_W-1]}}, s1_sample};
    assign b_ext = {{SAMPLE_W{1'b0}}, 1'b0, s1_level};
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
        end else begin
            sample_out_valid <= s1_valid;
            if (s1_valid) begin
                sample_out <= SAMPLE_W'(prod >>> LEVEL_W);
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope stepped on sample_tick, with a VCA scaling the
// incoming tone samples by the current level for the sigma-delta DAC.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned LEVEL_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       gate,
    input  logic        [LEVEL_W-1:0]  attack_rate,
    input  logic        [LEVEL_W-1:0]  decay_rate,
    input  logic        [LEVEL_W-1:0]  sustain_level,
    input  logic        [LEVEL_W-1:0]  release_rate,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_in_valid,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_out_valid,
    output logic        [LEVEL_W-1:0]  env_level,
    output logic        [2:0]          env_state
);

    localparam logic [LEVEL_W-1:0] LVL_MAX = '1;

    logic gate_meta;
    logic gate_s;
    logic gate_prev;
    logic rise;

    env_state_t         state;
    env_state_t         state_nxt;
    logic [LEVEL_W-1:0] level;
    logic [LEVEL_W-1:0] level_nxt;

    logic        [LEVEL_W:0] attack_sum;
    logic signed [LEVEL_W:0] decay_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_meta <= 1'b0;
            gate_s    <= 1'b0;
        end else begin
            gate_meta <= gate;
            gate_s    <= gate_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            level     <= '0;
            gate_prev <= 1'b0;
        end else if (sample_tick) begin
            state     <= state_nxt;
            level     <= level_nxt;
            gate_prev <= gate_s;
        end
    end

    assign rise       = gate_s & ~gate_prev;
    assign attack_sum = {1'b0, level} + {1'b0, attack_rate};
    assign decay_diff = $signed({1'b0, level}) - $signed({1'b0, decay_rate});

    always_comb begin
        state_nxt = state;
        level_nxt = level;
        case (state)
            IDLE: begin
                level_nxt = '0;
                if (rise) begin
                    state_nxt = ATTACK;
                end
            end
            ATTACK: begin
                if (!gate_s) begin
                    state_nxt = RELEASE;
                end else if (attack_rate == '0 || attack_sum >= {1'b0, LVL_MAX}) begin
                    level_nxt = LVL_MAX;
                    state_nxt = DECAY;
                end else begin
                    level_nxt = attack_sum[LEVEL_W-1:0];
                end
            end
            DECAY: begin
                if (!gate_s) begin
                    state_nxt = RELEASE;
                end else if (decay_rate == '0 ||
                             decay_diff <= $signed({1'b0, sustain_level})) begin
                    level_nxt = sustain_level;
                    state_nxt = SUSTAIN;
                end else begin
                    level_nxt = decay_diff[LEVEL_W-1:0];
                end
            end
            SUSTAIN: begin
                level_nxt = sustain_level;
                if (!gate_s) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                // Retrigger resumes the attack from wherever the release has got to.
                if (rise) begin
                    state_nxt = ATTACK;
                end else if (release_rate == '0 || level <= release_rate) begin
                    level_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    level_nxt = level - release_rate;
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = '0;
            end
        endcase
    end

    assign env_level = level;
    assign env_state = state;

    env_vca #(
        .SAMPLE_W (SAMPLE_W),
        .LEVEL_W  (LEVEL_W)
    ) u_vca (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .level            (level),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

endmodule
